// File: rtl/hex_fill_streamer.sv
// hex_fill_streamer: accepts one axial centre plus a radius per job and
// streams every cell of the filled hexagon (row-major in dq, then dr) over a
// valid/ready handshake, tagged with hex distance, index and a last flag.
module hex_fill_streamer #(
  parameter int COORD_W    = 16,
  parameter int MAX_RADIUS = 15,
  parameter int RAD_W      = 4,
  parameter int DEPTH_W    = 8,
  parameter int IDX_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] q_center,
  input  logic [COORD_W-1:0] r_center,
  input  logic [RAD_W-1:0]   radius,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] q_out,
  output logic [COORD_W-1:0] r_out,
  output logic [DEPTH_W-1:0] depth,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               clamped,
  output logic               busy
);

  // Offsets span -R..+R, and R - dq reaches 2R; three spare bits cover both.
  localparam int DW = RAD_W + 3;

  localparam logic [RAD_W:0]          MAXR_EXT = (RAD_W+1)'(MAX_RADIUS);
  localparam logic signed [DW-1:0]    MAXR_S   = DW'(MAX_RADIUS);
  localparam logic signed [DW-1:0]    ONE_S    = DW'(1);
  localparam logic [IDX_W-1:0]        ONE_IDX  = IDX_W'(1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                     state_q, state_d;
  logic signed [DW-1:0]       rad_q, rad_d;
  logic signed [DW-1:0]       dq_q, dq_d;
  logic signed [DW-1:0]       dr_q, dr_d;
  logic signed [COORD_W-1:0]  qc_q, qc_d;
  logic signed [COORD_W-1:0]  rc_q, rc_d;
  logic signed [COORD_W-1:0]  qo_q, qo_d;
  logic signed [COORD_W-1:0]  ro_q, ro_d;
  logic [DEPTH_W-1:0]         dep_q, dep_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       last_q, last_d;
  logic                       clamp_q, clamp_d;

  logic                       over;
  logic signed [DW-1:0]       rad_in_s;
  logic signed [DW-1:0]       r_sel;
  logic signed [DW-1:0]       nq, nr;

  function automatic logic signed [DW-1:0] smin(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DW-1:0] sabs(input logic signed [DW-1:0] a);
    return (a < 0) ? -a : a;
  endfunction

  // Sign-extend a small offset to coordinate width; the add then wraps mod 2^COORD_W.
  function automatic logic signed [COORD_W-1:0] sext(input logic signed [DW-1:0] d);
    return {{(COORD_W-DW){d[DW-1]}}, d};
  endfunction

  // Hex distance of an axial offset from the centre.
  function automatic logic [DEPTH_W-1:0] depth_of(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    logic signed [DW-1:0] s;
    logic signed [DW-1:0] m;
    s = a + b;
    m = smax(sabs(a), smax(sabs(b), sabs(s)));
    return DEPTH_W'($unsigned(m));
  endfunction

  assign over     = ({1'b0, radius} > MAXR_EXT);
  assign rad_in_s = {{(DW-RAD_W){1'b0}}, radius};

  // Next-state logic: load cell 0 on acceptance, step the scan on each handshake.
  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    dq_d    = dq_q;
    dr_d    = dr_q;
    qc_d    = qc_q;
    rc_d    = rc_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dep_d   = dep_q;
    idx_d   = idx_q;
    last_d  = last_q;
    clamp_d = clamp_q;
    r_sel   = '0;
    nq      = '0;
    nr      = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_sel   = over ? MAXR_S : rad_in_s;
          clamp_d = over;
          rad_d   = r_sel;
          dq_d    = -r_sel;
          dr_d    = '0;
          qc_d    = q_center;
          rc_d    = r_center;
          qo_d    = q_center + sext(-r_sel);
          ro_d    = r_center;
          dep_d   = depth_of(-r_sel, '0);
          idx_d   = '0;
          last_d  = (r_sel == '0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            // Stay in this column while dr has room, otherwise open the next one.
            if (dr_q < smin(rad_q, rad_q - dq_q)) begin
              nq = dq_q;
              nr = dr_q + ONE_S;
            end else begin
              nq = dq_q + ONE_S;
              nr = smax(-rad_q, -rad_q - nq);
            end
            dq_d   = nq;
            dr_d   = nr;
            qo_d   = qc_q + sext(nq);
            ro_d   = rc_q + sext(nr);
            dep_d  = depth_of(nq, nr);
            idx_d  = idx_q + ONE_IDX;
            last_d = (nq == rad_q) && (nr == smin(rad_q, rad_q - nq));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered output fields; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      dq_q    <= '0;
      dr_q    <= '0;
      qc_q    <= '0;
      rc_q    <= '0;
      qo_q    <= '0;
      ro_q    <= '0;
      dep_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      dq_q    <= dq_d;
      dr_q    <= dr_d;
      qc_q    <= qc_d;
      rc_q    <= rc_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dep_q   <= dep_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      clamp_q <= clamp_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign q_out     = qo_q;
  assign r_out     = ro_q;
  assign depth     = dep_q;
  assign out_index = idx_q;
  assign out_last  = last_q;
  assign clamped   = clamp_q;

endmodule

// File: tb/tb_hex_fill_streamer.sv
// Testbench for hex_fill_streamer: scenario tasks against a reference model
// that enumerates the hexagon from the distance rule directly.
module tb_hex_fill_streamer;

  localparam int MAXR = 3;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  d;
    logic [15:0] idx;
    logic        last;
    logic        clamp;
  } cell_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q_center;
  logic [15:0] r_center;
  logic [3:0]  radius;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q_out;
  logic [15:0] r_out;
  logic [7:0]  depth;
  logic [15:0] out_index;
  logic        out_last;
  logic        clamped;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  cell_t got[$];
  cell_t expq[$];
  int    stall_err;
  bit    timed_out;

  hex_fill_streamer #(
    .COORD_W(16), .MAX_RADIUS(MAXR), .RAD_W(4), .DEPTH_W(8), .IDX_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .q_center(q_center), .r_center(r_center), .radius(radius),
    .out_valid(out_valid), .out_ready(out_ready), .q_out(q_out), .r_out(r_out),
    .depth(depth), .out_index(out_index), .out_last(out_last),
    .clamped(clamped), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All cells within hex distance R of the centre, scanned dq-major then dr.
  task automatic build_model(input int qc, input int rc, input int rad);
    int R;
    int k;
    int d;
    cell_t c;
    R = (rad > MAXR) ? MAXR : rad;
    expq.delete();
    k = 0;
    for (int dq = -R; dq <= R; dq++) begin
      for (int dr = -R; dr <= R; dr++) begin
        d = (dq < 0) ? -dq : dq;
        if (((dr < 0) ? -dr : dr) > d) d = (dr < 0) ? -dr : dr;
        if (((dq + dr < 0) ? -(dq + dr) : dq + dr) > d) d = (dq + dr < 0) ? -(dq + dr) : dq + dr;
        if (d <= R) begin
          c.q = 16'(qc + dq);
          c.r = 16'(rc + dr);
          c.d = 8'(d);
          c.idx = 16'(k);
          c.last = 1'b0;
          c.clamp = (rad > MAXR);
          expq.push_back(c);
          k++;
        end
      end
    end
    expq[expq.size()-1].last = 1'b1;
  endtask

  // Present a job and wait (bounded) until it is accepted.
  task automatic start_job(input int qc, input int rc, input int rad, output bit ok);
    q_center = 16'(qc);
    r_center = 16'(rc);
    radius   = 4'(rad);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Gather cells until the last handshake, recording stall-stability violations.
  task automatic collect(input bit rnd, output int cycles);
    cell_t cur;
    cell_t snap;
    bit    prev_stall;
    bit    done;
    got.delete();
    stall_err = 0;
    timed_out = 1'b0;
    prev_stall = 1'b0;
    done = 1'b0;
    cycles = 0;
    snap = '0;
    while (!done && cycles < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cur.q = q_out; cur.r = r_out; cur.d = depth; cur.idx = out_index;
      cur.last = out_last; cur.clamp = clamped;
      if (out_valid) begin
        if (prev_stall && cur !== snap) stall_err++;
        if (out_ready) begin
          got.push_back(cur);
          if (out_last) done = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      snap = cur;
      tick();
      cycles++;
    end
    out_ready = 1'b1;
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b/%b want=0/0", out_valid, busy); end
    n_checks++; if ({q_out, r_out, depth, out_index} !== '0) begin n_fail++; $display("FAIL reset_fields got=%0h %0h %0h %0h want=0", q_out, r_out, depth, out_index); end
    n_checks++; if (out_last !== 1'b0 || clamped !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b/%b want=0/0", out_last, clamped); end
  endtask

  task automatic test_radius1();
    int hq[7] = '{9, 9, 10, 10, 10, 11, 11};
    int hr[7] = '{-4, -3, -5, -4, -3, -5, -4};
    int hd[7] = '{1, 1, 1, 0, 1, 1, 1};
    bit ok;
    int cyc;
    start_job(10, -4, 1, ok);
    n_checks++; if (!ok || out_valid !== 1'b1) begin n_fail++; $display("FAIL r1_latency got valid=%b want=1", out_valid); end
    collect(1'b0, cyc);
    n_checks++; if (got.size() != 7 || cyc != 7 || timed_out) begin n_fail++; $display("FAIL r1_count got=%0d cells/%0d cycles want=7/7", got.size(), cyc); end
    for (int i = 0; i < got.size() && i < 7; i++) begin
      n_checks++;
      if (got[i].q !== 16'(hq[i]) || got[i].r !== 16'(hr[i]) || got[i].d !== 8'(hd[i]) ||
          got[i].idx !== 16'(i) || got[i].last !== (i == 6)) begin
        n_fail++;
        $display("FAIL r1_cell%0d got=(%0d,%0d) d=%0d i=%0d l=%b want=(%0d,%0d) d=%0d i=%0d l=%b", i,
                 $signed(got[i].q), $signed(got[i].r), got[i].d, got[i].idx, got[i].last,
                 hq[i], hr[i], hd[i], i, (i == 6));
      end
    end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL r1_turnaround got rdy=%b vld=%b want=1/0", in_ready, out_valid); end
  endtask

  task automatic test_radius0();
    bit ok;
    int cyc;
    start_job(0, 0, 0, ok);
    collect(1'b0, cyc);
    n_checks++;
    if (got.size() != 1 || cyc != 1 || got[0] !== cell_t'({16'd0, 16'd0, 8'd0, 16'd0, 1'b1, 1'b0})) begin
      n_fail++;
      $display("FAIL r0_cell got=%0d cells first=%h want=1 cell (0,0) d0 last", got.size(),
               (got.size() > 0) ? got[0] : cell_t'('0));
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    start_job(-100, 37, 2, ok);
    build_model(-100, 37, 2);
    collect(1'b1, cyc);
    n_checks++; if (got.size() != 19 || timed_out) begin n_fail++; $display("FAIL bp_count got=%0d want=19", got.size()); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d changes want=0", stall_err); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++;
      if (got[i] !== expq[i]) begin n_fail++; $display("FAIL bp_cell%0d got=%h want=%h", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int cyc;
    int maxd;
    int nclamp;
    start_job(3, 3, 15, ok);
    collect(1'b0, cyc);
    maxd = 0; nclamp = 0;
    foreach (got[i]) begin
      if (int'(got[i].d) > maxd) maxd = int'(got[i].d);
      if (got[i].clamp) nclamp++;
    end
    n_checks++; if (got.size() != 37 || cyc != 37) begin n_fail++; $display("FAIL clamp_count got=%0d/%0d want=37/37", got.size(), cyc); end
    n_checks++; if (nclamp != got.size() || clamped !== 1'b1) begin n_fail++; $display("FAIL clamp_flag got=%0d flagged now=%b want=%0d/1", nclamp, clamped, got.size()); end
    n_checks++; if (maxd != 3) begin n_fail++; $display("FAIL clamp_maxdepth got=%0d want=3", maxd); end
    start_job(3, 3, 2, ok);
    n_checks++; if (clamped !== 1'b0) begin n_fail++; $display("FAIL clamp_clear got=%b want=0", clamped); end
    collect(1'b0, cyc);
    n_checks++; if (got.size() != 19) begin n_fail++; $display("FAIL clamp_next_count got=%0d want=19", got.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    start_job(32767, -32768, 1, ok);
    build_model(32767, -32768, 1);
    collect(1'b0, cyc);
    n_checks++;
    if (got.size() != 7 || got[6].q !== 16'h8000 || got[6].r !== 16'h8000) begin
      n_fail++; $display("FAIL wrap_qplus got=%0d cells (%h,%h) want=(8000,8000)", got.size(),
                         (got.size() > 6) ? got[6].q : 16'hx, (got.size() > 6) ? got[6].r : 16'hx);
    end
    n_checks++;
    if (got.size() != 7 || got[2].q !== 16'h7fff || got[2].r !== 16'h7fff) begin
      n_fail++; $display("FAIL wrap_rminus got=(%h,%h) want=(7fff,7fff)",
                         (got.size() > 2) ? got[2].q : 16'hx, (got.size() > 2) ? got[2].r : 16'hx);
    end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++;
      if (got[i] !== expq[i]) begin n_fail++; $display("FAIL wrap_cell%0d got=%h want=%h", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    start_job(40, -40, 2, ok);
    out_ready = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (out_valid && out_index == 16'd5) begin hit = 1'b1; break; end
      tick();
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach got index=%0d want=5", out_index); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({q_out, r_out, depth, out_index} !== '0) begin n_fail++; $display("FAIL rstmid_fields got=%h %h %h %h want=0", q_out, r_out, depth, out_index); end
    n_checks++; if ({out_valid, out_last, busy, clamped} !== 4'b0000 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ctrl got vld/last/busy/clamp=%b%b%b%b rdy=%b want=0000/1", out_valid, out_last, busy, clamped, in_ready); end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_release got rdy=%b vld=%b want=1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    q_center = 16'd5; r_center = 16'd5; radius = 4'd1;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    tick();
    // Next job's fields change while the first is emitting; they must be ignored.
    q_center = 16'(-7); r_center = 16'd3; radius = 4'd2;
    build_model(5, 5, 1);
    collect(1'b0, cyc);
    n_checks++; if (got.size() != 7) begin n_fail++; $display("FAIL b2b_first_count got=%0d want=7", got.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++;
      if (got[i] !== expq[i]) begin n_fail++; $display("FAIL b2b_first_cell%0d got=%h want=%h", i, got[i], expq[i]); end
    end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble got rdy=%b vld=%b want=1/0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 16'd0 || q_out !== 16'(-9) || r_out !== 16'd3) begin
      n_fail++; $display("FAIL b2b_second_start got vld=%b i=%0d (%0d,%0d) want=1 0 (-9,3)", out_valid, out_index, $signed(q_out), $signed(r_out));
    end
    build_model(-7, 3, 2);
    collect(1'b0, cyc);
    n_checks++; if (got.size() != 19) begin n_fail++; $display("FAIL b2b_second_count got=%0d want=19", got.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++;
      if (got[i] !== expq[i]) begin n_fail++; $display("FAIL b2b_second_cell%0d got=%h want=%h", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    int qc;
    int rc;
    int rad;
    for (int j = 0; j < 8; j++) begin
      qc  = int'($signed(16'($urandom)));
      rc  = int'($signed(16'($urandom)));
      rad = int'($urandom_range(0, 5));
      start_job(qc, rc, rad, ok);
      build_model(qc, rc, rad);
      collect(1'b1, cyc);
      n_checks++; if (!ok || timed_out || got.size() != expq.size() || stall_err != 0) begin n_fail++; $display("FAIL rand%0d_count got=%0d stall=%0d want=%0d stall=0", j, got.size(), stall_err, expq.size()); end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
        n_checks++;
        if (got[i] !== expq[i]) begin n_fail++; $display("FAIL rand%0d_cell%0d got=%h want=%h", j, i, got[i], expq[i]); end
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    q_center  = '0;
    r_center  = '0;
    radius    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_radius1();
    test_radius0();
    test_backpressure();
    test_clamp();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_fill_streamer.md
# hex_fill_streamer

Streaming successor to the one-shot hexagonal fill rasterizer. It accepts one rounded axial centre hex per job and a runtime radius up to `MAX_RADIUS`. It then emits every cell of the filled hexagon, one per handshake, on a valid/ready stream, tagged with its hex distance from the centre, its index and a last flag. It sits between centre rounding and the per-hex depth/shade stage, and it removes the wide parallel output arrays of the previous generation.

## Interface
- `COORD_W`, 16: axial coordinate width, signed two's complement.
- `MAX_RADIUS`, 15: largest supported radius. Must be ≥ 0.
- `RAD_W`, 4: radius port width. Must hold `MAX_RADIUS`.
- `DEPTH_W`, 8: depth field width. Must hold `MAX_RADIUS`.
- `IDX_W`, 16: index/count width. Must hold 3·MAX_RADIUS·(MAX_RADIUS+1)+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: job request.
- `in_ready` out 1: job accepted when `in_valid && in_ready`.
- `q_center`, `r_center` in COORD_W: centre hex, signed.
- `radius` in RAD_W: requested radius, unsigned.
- `out_valid` out 1: a cell is presented.
- `out_ready` in 1: downstream accepts the cell.
- `q_out`, `r_out` out COORD_W: cell coordinates.
- `depth` out DEPTH_W: hex distance of the cell from the centre.
- `out_index` out IDX_W: 0-based position of the cell within the job.
- `out_last` out 1: final cell of the job.
- `clamped` out 1: the current or most recent job had `radius > MAX_RADIUS`.
- `busy` out 1: high whenever the state is EMIT.

## Operation
- FSM has two states: IDLE and EMIT. Reset state is IDLE.
- `in_ready` = (state == IDLE). `out_valid` = (state == EMIT). `busy` = `out_valid`.
- On acceptance:
  - Latch the centre.
  - Set R = min(radius, MAX_RADIUS) and `clamped` = (radius > MAX_RADIUS).
  - Set dq = −R, dr = 0, index = 0, then go to EMIT.
- Emission order is row-major:
  - Outer loop: dq runs from −R to +R.
  - Inner loop: dr runs from max(−R, −R−dq) to min(R, R−dq).
  - Total cells per job: 3R(R+1)+1.
- Output fields:
  - `q_out` = q_center + dq and `r_out` = r_center + dr, both taken modulo 2^COORD_W (wrap, no saturation).
  - `depth` = max(|dq|, |dr|, |dq+dr|), zero-extended.
- `out_last` is high when dq == R and dr == min(R, R−dq).
- Advance happens only on `out_valid && out_ready`:
  - If dr < its upper bound, increment dr.
  - Otherwise increment dq and set dr to the new lower bound.
  - Increment index.
- A handshake on `out_last` returns the FSM to IDLE.
- R = 0 gives a single cell: (q_center, r_center), depth 0, index 0, last = 1.
- Inputs are ignored while in EMIT. A job in progress is never altered.

## Timing
- Reset values (asynchronous, applied immediately on `reset_n` low):
  - state = IDLE, so `in_ready` = 1.
  - `out_valid`, `out_last`, `busy`, `clamped` = 0.
  - `q_out`, `r_out`, `depth`, `out_index` = 0.
- Reset mid-job abandons the job with no further cells. The first cycle after deassertion is IDLE.
- Latency: a job accepted at edge k presents cell 0 with `out_valid` = 1 in the cycle after edge k.
- Throughput: one cell per cycle while `out_ready` = 1. A job of radius R occupies the stream for exactly 3R(R+1)+1 cycles.
- Job turnaround: `in_ready` rises in the cycle after the last handshake. Jobs have a minimum one-cycle bubble between them.
- Stall: while `out_valid && !out_ready`, every output holds stable.
- All outputs are registered and have no combinational path from inputs. `in_ready` and `out_valid` decode the state register only.

## Test plan
- Radius 1, centre (10, −4), `out_ready` = 1:
  - Cells in order: (9,−4), (9,−3), (10,−5), (10,−4), (10,−3), (11,−5), (11,−4).
  - Depths: 1, 1, 1, 0, 1, 1, 1.
  - Indices 0–6; `out_last` only on index 6; `in_ready` returns one cycle later.
- Radius 0, centre (0,0): exactly one cell (0,0), depth 0, `out_last` = 1.
- Backpressure: radius 2 with `out_ready` toggling in a random pattern.
  - Exactly 19 cells arrive, in the same order and with the same fields as with `out_ready` held at 1.
  - Outputs stay constant across every stall cycle.
- Clamp:
  - `radius` = 15 with MAX_RADIUS = 3 emits 37 cells, `clamped` = 1, maximum depth 3.
  - The next job with `radius` = 2 clears `clamped`.
- Wrap: centre (32767, −32768), radius 1.
  - Cell (q+1, r) is output as (−32768, −32768).
  - Cell (q, r−1) is output as (32767, 32767).
- Reset and back-to-back:
  - Assert `reset_n` = 0 at index 5 of a radius-2 job: all outputs are 0 immediately and `in_ready` = 1 after release.
  - Hold `in_valid` high for two jobs: the second job's cell 0 appears two cycles after the first job's last handshake.
